// File: rtl/uart_sender.sv
// uart_sender: transmit half of the CPU serial link.
// Bytes written by the pipeline are queued in a small circular FIFO and
// shifted out on uart_tx as 8N1 frames (start, 8 data bits LSB first, stop).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   tx_data      byte to queue, sampled when tx_write = 1
//   tx_write     one-cycle write strobe
//   tx_full      FIFO holds FIFO_DEPTH bytes
//   tx_busy      FIFO non-empty or a frame in progress
//   tx_done      one-cycle pulse in the last cycle of each stop bit
//   tx_overflow  sticky: a write arrived while full and was dropped
//   uart_tx      registered serial line, idle high
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, waiting for the FIFO to become non-empty
// S_START | start bit (line low) for CLKS_PER_BIT cycles
// S_DATA  | data bit sh[0], CLKS_PER_BIT cycles each, 8 bits
// S_STOP  | stop bit (line high); pops the next byte at its last cycle
module uart_sender #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overflow,
    output logic       uart_tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   count;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    logic [CNT_W-1:0]   baud_cnt;
    logic [CNT_W-1:0]   baud_cnt_next;
    logic               baud_tc;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_idx_next;
    logic [7:0]         sh;
    logic [7:0]         sh_next;
    logic               uart_tx_next;

    // ---------------- FIFO ----------------
    assign fifo_empty = (count == '0);
    assign tx_full    = (count == OCC_W'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a write to a full FIFO is
    // still accepted when the FSM is draining it.
    assign push       = tx_write && (!tx_full || pop);
    assign tx_busy    = !fifo_empty || (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            if (tx_write && !push) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    assign baud_tc = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + CNT_W'(1);
        bit_idx_next  = bit_idx;
        sh_next       = sh;
        pop           = 1'b0;
        case (state)
            S_IDLE: begin
                baud_cnt_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    sh_next    = fifo_mem[rd_ptr];
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    state_next    = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_cnt_next = '0;
                    sh_next       = {1'b0, sh[7:1]};
                    bit_idx_next  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next frame with no idle gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        sh_next    = fifo_mem[rd_ptr];
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next    = S_IDLE;
                baud_cnt_next = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // uart_tx is registered, so its next value is decoded from the next
    // state; the line therefore changes on the same edge as the state.
    always_comb begin
        tx_done      = (state == S_STOP) && baud_tc;
        uart_tx_next = 1'b1;
        case (state_next)
            S_START: uart_tx_next = 1'b0;
            S_DATA:  uart_tx_next = sh_next[0];
            default: uart_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            sh       <= 8'h00;
            uart_tx  <= 1'b1;
        end else begin
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            sh       <= sh_next;
            uart_tx  <= uart_tx_next;
        end
    end

endmodule

// File: tb/tb_uart_sender.sv
module tb_uart_sender;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_write = 1'b0;
    logic       tx_full;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_overflow;
    logic       uart_tx;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];

    uart_sender #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_write   (tx_write),
        .tx_full    (tx_full),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_overflow(tx_overflow),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; leaves tx_write asserted, returns at the next negedge.
    task automatic drive(input logic [7:0] b, input bit accepted);
        tx_data  = b;
        tx_write = 1'b1;
        if (accepted) exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, tx_busy}, 32'd0);
    endtask

    // Line monitor: decodes frames, checks shape and tx_done placement,
    // and pops the scoreboard at each completed frame.
    initial begin
        int         c;
        int         k;
        bit         act;
        bit         err;
        logic [7:0] by;
        c   = 0;
        act = 1'b0;
        err = 1'b0;
        by  = 8'h00;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                act = 1'b0;
                c   = 0;
            end else if (!act) begin
                check("idle_done_low", {31'd0, tx_done}, 32'd0);
                if (uart_tx === 1'b0) begin
                    act = 1'b1;
                    c   = 1;
                    by  = 8'h00;
                    err = 1'b0;
                end
            end else begin
                if (c < CPB) begin
                    if (uart_tx !== 1'b0) err = 1'b1;
                end else if (c < 9 * CPB) begin
                    k = (c - CPB) / CPB;
                    if ((c - CPB) % CPB == 0) by[k] = uart_tx;
                    else if (uart_tx !== by[k]) err = 1'b1;
                end else begin
                    if (uart_tx !== 1'b1) err = 1'b1;
                end
                if (tx_done !== (c == 10 * CPB - 1)) err = 1'b1;
                if (c == 10 * CPB - 1) begin
                    check("frame_shape", {31'd0, err}, 32'd0);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL frame_unexpected: got %0h expected no frame", by);
                    end else begin
                        check("frame_byte", {24'd0, by}, {24'd0, exp_q.pop_front()});
                    end
                    act = 1'b0;
                end
                c++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nd;
        int d1;
        int d2;
        int w;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy",    {31'd0, tx_busy}, 32'd0);
        check("rst_full",    {31'd0, tx_full}, 32'd0);
        check("rst_done",    {31'd0, tx_done}, 32'd0);
        check("rst_ovf",     {31'd0, tx_overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single byte, latency and stop/done/busy timing
        drive(8'hA5, 1'b1);
        tx_write = 1'b0;
        check("t1_busy_rise", {31'd0, tx_busy}, 32'd1);
        check("t1_line_idle", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        check("t1_start_fall", {31'd0, uart_tx}, 32'd0);
        repeat (39) @(negedge clk);
        check("t1_done", {31'd0, tx_done}, 32'd1);
        check("t1_stop_line", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        check("t1_busy_fall", {31'd0, tx_busy}, 32'd0);
        check("t1_done_low", {31'd0, tx_done}, 32'd0);

        // 2: back-to-back frames
        drive(8'h00, 1'b1);
        drive(8'hFF, 1'b1);
        tx_write = 1'b0;
        cyc = 1;
        nd  = 0;
        d1  = 0;
        d2  = 0;
        while (tx_busy === 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (tx_done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = cyc;
                else d2 = cyc;
            end
        end
        check("t2_done_count", nd, 2);
        check("t2_done1_cycle", d1, 40);
        check("t2_done_spacing", d2 - d1, 40);
        check("t2_busy_fall", cyc, 81);

        // 3: overflow
        for (int i = 1; i <= 5; i++) drive(8'(i), 1'b1);
        drive(8'h06, 1'b0);
        tx_write = 1'b0;
        check("t3_full", {31'd0, tx_full}, 32'd1);
        check("t3_ovf", {31'd0, tx_overflow}, 32'd1);
        wait_idle();
        check("t3_ovf_sticky", {31'd0, tx_overflow}, 32'd1);
        check("t3_queue_drained", exp_q.size(), 0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t3_ovf_cleared", {31'd0, tx_overflow}, 32'd0);

        // 4: push/pop collision at the end of STOP with a full FIFO
        for (int i = 0; i < 5; i++) drive(8'(8'h10 + i), 1'b1);
        tx_write = 1'b0;
        check("t4_full_pre", {31'd0, tx_full}, 32'd1);
        repeat (36) @(negedge clk);
        check("t4_stop_end", {31'd0, tx_done}, 32'd1);
        drive(8'h3C, 1'b1);
        tx_write = 1'b0;
        check("t4_full_post", {31'd0, tx_full}, 32'd1);
        check("t4_no_ovf", {31'd0, tx_overflow}, 32'd0);
        wait_idle();
        check("t4_no_ovf_end", {31'd0, tx_overflow}, 32'd0);
        check("t4_queue_drained", exp_q.size(), 0);

        // 5: reset during data bit 3 of 0x55
        drive(8'h55, 1'b1);
        tx_write = 1'b0;
        repeat (18) @(negedge clk);
        check("t5_bit3", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_rst_line", {31'd0, uart_tx}, 32'd1);
        check("t5_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("t5_rst_full", {31'd0, tx_full}, 32'd0);
        check("t5_rst_done", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(8'h81, 1'b1);
        tx_write = 1'b0;
        wait_idle();
        check("t5_queue_drained", exp_q.size(), 0);

        // 6: stream 12 bytes, writing whenever not full (pointers wrap 3x)
        for (int i = 0; i < 12; i++) begin
            w = 0;
            if (tx_full === 1'b1) tx_write = 1'b0;
            while (tx_full === 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            check("t6_space", {31'd0, tx_full}, 32'd0);
            drive(8'(8'hC0 + i), 1'b1);
        end
        tx_write = 1'b0;
        wait_idle();
        check("t6_no_ovf", {31'd0, tx_overflow}, 32'd0);
        check("t6_queue_drained", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_sender.md
# uart_sender

Transmit half of the CPU's serial link. It accepts bytes written by the pipeline, which the MEM/WB stage issues as a store to the UART TX register. It buffers them in a small FIFO and shifts each one out on `uart_tx` as an 8N1 frame at a fixed baud rate. It sits beside the receive path at the top level and drives the board's `uart_tx` pin.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); legal range ≥ 2.
- `FIFO_DEPTH`, default 4: byte entries in the TX FIFO; must be a power of 2, ≥ 2.

**Ports**
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `tx_data`  in  8: byte to send; sampled when `tx_write` = 1.
- `tx_write`  in  1: one-cycle write strobe from the CPU.
- `tx_full`  out  1: FIFO holds `FIFO_DEPTH` bytes.
- `tx_busy`  out  1: FIFO non-empty or a frame in progress.
- `tx_done`  out  1: one-cycle pulse in the last cycle of each stop bit.
- `tx_overflow`  out  1: sticky; a write arrived while the FIFO was full and the byte was dropped.
- `uart_tx`  out  1: serial line, idle high, registered.

## Operation

**FIFO**
- Circular buffer with read/write pointers and an occupancy count of width log2(`FIFO_DEPTH`)+1.
- Pointers wrap modulo `FIFO_DEPTH`.
- Push: `tx_write` = 1 and (not full, or a pop occurs in the same cycle).
- Simultaneous push and pop when full: the pop frees the slot, the push is accepted, and the count is unchanged.
- Simultaneous push and pop at any occupancy: the count is unchanged.
- Write while full with no pop: the byte is discarded and `tx_overflow` is set. It clears only on `rst`.
- `tx_full` = (count == `FIFO_DEPTH`), decoded from registers.
- `tx_busy` = (count != 0) or (state != IDLE).

**Transmit state machine**

States: IDLE, START, DATA, STOP.
- **IDLE**
  - `uart_tx` = 1.
  - If the FIFO is non-empty: pop the head into shift register `sh`, clear the baud counter, and go to START.
- **START**
  - `uart_tx` = 0 for `CLKS_PER_BIT` cycles.
  - Then go to DATA with bit index 0.
- **DATA**
  - `uart_tx` = `sh[0]` (LSB first).
  - Each bit lasts `CLKS_PER_BIT` cycles; at the end, shift `sh` right and increment the index.
  - After bit 7, go to STOP.
- **STOP**
  - `uart_tx` = 1 for `CLKS_PER_BIT` cycles.
  - `tx_done` = 1 in the last of those cycles.
  - Exit: if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap). Otherwise go to IDLE.

**Baud counter**
- Counts 0..`CLKS_PER_BIT`-1, with width $clog2(`CLKS_PER_BIT`).
- The terminal count marks the end of a bit.
- The counter restarts at 0 on every state change.

**Reset**
- Asynchronous: all state is cleared immediately, including mid-frame.
- Reset values: `uart_tx` = 1, state = IDLE, FIFO empty, `tx_full` = 0, `tx_busy` = 0, `tx_done` = 0, `tx_overflow` = 0.
- A frame aborted by reset is not resumed.

## Timing

- **Write to line:** `tx_write` sampled at edge k with an empty FIFO and the FSM in IDLE.
  - The byte is in the FIFO after edge k.
  - The pop and the START entry occur at edge k+1, so `uart_tx` falls after edge k+1.
  - Latency is 2 edges from strobe to start bit.
- **Frame length:** exactly 10·`CLKS_PER_BIT` cycles from start-bit fall to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins the cycle after the previous stop bit's last cycle.
- **Status visibility:**
  - `tx_busy` rises after edge k.
  - `tx_busy` falls the cycle after the last stop bit when the FIFO is empty.
  - `tx_full` updates the cycle after the push or pop that changes the count.
- **Throughput:** sustained one byte per 10·`CLKS_PER_BIT` cycles. The CPU must poll `tx_full` before writing; there is no back-pressure beyond the drop flag.

## Test plan

All scenarios run with `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.

1. **Single byte.** Write 0xA5 at edge 0.
   - `uart_tx` is low for edges 1–4.
   - Data bits are 1,0,1,0,0,1,0,1, four cycles each.
   - Stop bit (high) covers edges 37–40.
   - `tx_done` is high only in the cycle after edge 40; `tx_busy` falls after edge 41.
2. **Back-to-back.** Write 0x00 then 0xFF on consecutive cycles.
   - The two frames are contiguous, 80 cycles total with no idle gap.
   - `tx_done` pulses twice, 40 cycles apart.
3. **Overflow.** Write 6 bytes 0x01..0x06 on consecutive cycles.
   - `tx_full` is observed high.
   - Exactly one byte is dropped (0x06), and `tx_overflow` = 1 and stays 1.
   - Line output is 0x01..0x05 in order.
4. **Push/pop collision.** With the FIFO full and the FSM ending STOP, write 0x3C in the same cycle as the pop.
   - The byte is accepted, the count stays 4, and `tx_overflow` stays 0.
5. **Reset mid-frame.** Assert `rst` during DATA bit 3 of 0x55.
   - `uart_tx` = 1 immediately; all status outputs go to 0.
   - After release, writing 0x81 yields one clean frame.
6. **Wrap-around.** Stream 12 bytes, writing whenever `tx_full` = 0.
   - All 12 bytes are transmitted in order and the pointers wrap three times.
